// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg: shared definitions for the fifo_flex FWFT buffer.
//   fifo_depth(addr_w) : number of entries addressed by an addr_w-bit pointer
//   fifo_status_t      : bundle of the status flags decoded by fifo_flex_ctrl
package fifo_flex_pkg;

  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_flex_ctrl.sv
// fifo_flex_ctrl: pointer, occupancy and error-flag control for fifo_flex.
// Optional feature macro: FIFO_FLUSH_EN (adds flush_i).
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   flush_i          (FIFO_FLUSH_EN only) empties the FIFO, flags kept
//   rd_i, wr_i       raw pop / push requests
//   w_addr_o         storage write address (tail)
//   r_addr_o         storage read address (head)
//   w_en_o           storage write enable (effective write)
//   count_o          occupancy 0..2**ADDR_WIDTH
//   status_o         decoded status flags
module fifo_flex_ctrl
  import fifo_flex_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
`ifdef FIFO_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  rd_i,
  input  logic                  wr_i,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [ADDR_WIDTH-1:0] r_addr_o,
  output logic                  w_en_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output fifo_status_t          status_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, full, re, we;

  // The count alone decides full/empty; pointers are never compared.
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    re          = rd_i & ~empty;
    // A write while full is admitted only when a pop frees the slot.
    we          = wr_i & (~full | rd_i);
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (wr_i & full & ~rd_i);
    underflow_d = underflow_q | (rd_i & empty);
    if (we) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
    if (re) r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
    case ({we, re})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
`ifdef FIFO_FLUSH_EN
    // Flush overrides rd/wr but leaves the sticky error flags untouched.
    if (flush_i) begin
      we          = 1'b0;
      re          = 1'b0;
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      count_d     = '0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign w_addr_o = w_ptr_q;
  assign r_addr_o = r_ptr_q;
  assign w_en_o   = we;
  assign count_o  = count_q;

  always_comb begin
    status_o              = '0;
    status_o.empty        = empty;
    status_o.full         = full;
    status_o.almost_empty = (count_q <= AEMPTY_C);
    status_o.almost_full  = (count_q >= AFULL_C);
    status_o.overflow     = overflow_q;
    status_o.underflow    = underflow_q;
  end

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised first-word-fall-through FIFO with occupancy count,
// programmable almost-full/almost-empty flags and sticky overflow/underflow.
// Optional feature macro: FIFO_FLUSH_EN (adds the flush input).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             (FIFO_FLUSH_EN only) empty the FIFO, error flags kept
//   rd, wr, w_data    pop head / push w_data
//   r_data            head entry, valid while empty=0 (zero read latency)
//   empty, full, almost_empty, almost_full, count   occupancy status
//   overflow, underflow                              sticky error flags
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr, r_addr;
  logic                  w_en;
  fifo_status_t          status;

  fifo_flex_ctrl #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_ctrl (
    .clk_i    (clk),
    .reset_i  (reset),
`ifdef FIFO_FLUSH_EN
    .flush_i  (flush),
`endif
    .rd_i     (rd),
    .wr_i     (wr),
    .w_addr_o (w_addr),
    .r_addr_o (r_addr),
    .w_en_o   (w_en),
    .count_o  (count),
    .status_o (status)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_en) mem_q[w_addr] <= w_data;
  end

  assign r_data       = mem_q[r_addr];
  assign empty        = status.empty;
  assign full         = status.full;
  assign almost_empty = status.almost_empty;
  assign almost_full  = status.almost_full;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: self-checking bench for fifo_flex (ADDR_WIDTH=4,
// AFULL_THRESH=14, AEMPTY_THRESH=2). Build with FIFO_FLUSH_EN defined to
// also exercise flush.
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] w_data = '0;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue plus the two sticky flags.
  logic [7:0] mq[$];
  bit         m_of, m_uf;

  fifo_flex #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef FIFO_FLUSH_EN
    .flush        (flush),
`endif
    .rd           (rd),
    .wr           (wr),
    .w_data       (w_data),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit w, input logic [7:0] d,
                              input bit rst, input bit fl);
    bit was_full, was_empty;
    if (rst) begin
      mq.delete(); m_of = 0; m_uf = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      was_full  = (mq.size() == 16);
      was_empty = (mq.size() == 0);
      if (r && was_empty) m_uf = 1;
      if (w && was_full && !r) m_of = 1;
      if (r && !was_empty) void'(mq.pop_front());
      if (w && (!was_full || r)) mq.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == 16));
    chk("almost_empty", int'(almost_empty), int'(n <= 2));
    chk("almost_full", int'(almost_full), int'(n >= 14));
    chk("overflow", int'(overflow), int'(m_of));
    chk("underflow", int'(underflow), int'(m_uf));
    if (n > 0) chk("r_data", int'(r_data), int'(mq[0]));
  endtask

  // Apply one cycle of inputs, then compare against the model just after the edge.
  task automatic step(input bit r, input bit w, input logic [7:0] d,
                      input bit rst, input bit fl);
    rd = r; wr = w; w_data = d; reset = rst; flush = fl;
    @(posedge clk);
    model_update(r, w, d, rst, fl);
    #1;
    check_all();
  endtask

  typedef struct {
    bit         rd, wr;
    logic [7:0] wd;
    int         cnt;
    bit         ae, af, fu, of;
    logic [7:0] rdat;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit w, input logic [7:0] d, input int c,
                              input bit o, input logic [7:0] h);
    vec_t v;
    v.rd = r; v.wr = w; v.wd = d; v.cnt = c;
    v.ae = (c <= 2); v.af = (c >= 14); v.fu = (c == 16); v.of = o; v.rdat = h;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    logic [7:0] got[$];
    logic [7:0] sent[$];
    int         maxc;
    int         bias;

    // Fill 0x01..0x10, then an overflow write, then a simultaneous rd/wr at full.
    for (int i = 0; i < 16; i++) tbl[i] = mk(1'b0, 1'b1, 8'(i + 1), i + 1, 1'b0, 8'h01);
    tbl[16] = mk(1'b0, 1'b1, 8'hAA, 16, 1'b1, 8'h01);
    tbl[17] = mk(1'b1, 1'b1, 8'h55, 16, 1'b1, 8'h02);

    // Reset state
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].wd, 0, 0);
      chk("tbl_count", int'(count), tbl[i].cnt);
      chk("tbl_aempty", int'(almost_empty), int'(tbl[i].ae));
      chk("tbl_afull", int'(almost_full), int'(tbl[i].af));
      chk("tbl_full", int'(full), int'(tbl[i].fu));
      chk("tbl_ovf", int'(overflow), int'(tbl[i].of));
      chk("tbl_rdata", int'(r_data), int'(tbl[i].rdat));
    end

    // Drain: 0x02..0x10 then 0x55 after wrap, never 0xAA.
    for (int i = 0; i < 16; i++) begin
      chk("drain_rdata", int'(r_data), (i < 15) ? i + 2 : 'h55);
      step(1, 0, 8'h00, 0, 0);
    end
    chk("drain_empty", int'(empty), 1);

    // Empty with rd & wr together: read ignored, write accepted.
    step(1, 1, 8'h33, 0, 0);
    chk("erw_udf", int'(underflow), 1);
    chk("erw_count", int'(count), 1);
    chk("erw_rdata", int'(r_data), 'h33);
    chk("erw_empty", int'(empty), 0);

    // Streaming with pointer wrap: 20 writes, reading from the 3rd word on.
    step(0, 0, 8'h00, 1, 0);
    maxc = 0;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      sent.push_back(d);
      if (i >= 2 && !empty) got.push_back(r_data);
      step(i >= 2, 1, d, 0, 0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    while (!empty && got.size() < 20) begin
      got.push_back(r_data);
      step(1, 0, 8'h00, 0, 0);
    end
    chk("wrap_maxcount_le3", int'(maxc <= 3), 1);
    chk("wrap_len", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("wrap_order", int'(got[i]), int'(sent[i]));

`ifdef FIFO_FLUSH_EN
    // Flush with wr asserted: FIFO empties, flags untouched, new data next.
    step(1, 0, 8'h00, 0, 0); // sets underflow so flag retention is visible
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
    step(0, 1, 8'hEE, 0, 1);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_udf_kept", int'(underflow), 1);
    chk("flush_ovf_kept", int'(overflow), 0);
    step(0, 1, 8'h77, 0, 0);
    chk("flush_next", int'(r_data), 'h77);
`endif

    // Randomised phases with varying read/write bias, occasional reset/flush.
    for (int p = 0; p < 8; p++) begin
      bias = (p % 2 == 0) ? 80 : 25;
      for (int c = 0; c < 250; c++) begin
        bit r, w, rs, fl;
        w  = ($urandom_range(0, 99) < bias);
        r  = ($urandom_range(0, 99) < 100 - bias);
        rs = ($urandom_range(0, 299) == 0);
`ifdef FIFO_FLUSH_EN
        fl = ($urandom_range(0, 149) == 0);
`else
        fl = 0;
`endif
        step(r, w, 8'($urandom), rs, fl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised first-word-fall-through (FWFT) FIFO. It is the successor to the team's basic fifo/fifo_ctrl/reg_file buffer. It adds:
- an occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags

It sits between producer and consumer stages wherever a buffer needs back-pressure headroom, for example between the input sampler and the processing datapath.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address width. Depth is 2**ADDR_WIDTH entries.
- AFULL_THRESH, 2**ADDR_WIDTH-2, almost_full asserts when count >= AFULL_THRESH. Legal range 1..2**ADDR_WIDTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH. Legal range 0..2**ADDR_WIDTH-1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rd  input  1  pop the head entry (acknowledge of r_data).
- wr  input  1  push w_data to the tail.
- w_data  input  DATA_WIDTH  write data.
- r_data  output  DATA_WIDTH  head entry, valid whenever empty=0 (FWFT).
- empty  output  1  count == 0.
- full  output  1  count == 2**ADDR_WIDTH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- almost_full  output  1  count >= AFULL_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow  output  1  sticky; set by a dropped write.
- underflow  output  1  sticky; set by an ignored read.

Behaviour:
- Reset (synchronous, active-high): w_ptr=0, r_ptr=0, count=0, overflow=0, underflow=0. Outputs follow as empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0 ? 1 : 0), which is 0 for legal thresholds.
- Storage contents are not cleared by reset. r_data is don't-care while empty.
- FWFT read path: r_data = mem[r_ptr], combinational from registered state, zero read latency. rd consumes the current head; the next entry appears on r_data in the following cycle.
- Write latency: a word written in cycle N is visible on r_data in cycle N+1 if the FIFO was empty. empty deasserts in cycle N+1.
- Effective read: re = rd & ~empty.
- Effective write: we = wr & (~full | rd).
  - A write while full is accepted only if a read occurs in the same cycle.
- Pointers are ADDR_WIDTH bits and wrap from 2**ADDR_WIDTH-1 to 0. Pointer comparison is never used for full/empty; the count is authoritative.
- count update per cycle:
  - we & ~re: count+1
  - re & ~we: count-1
  - both or neither: unchanged
- Empty with rd & wr in the same cycle: the read is ignored, the write is accepted, count becomes 1, and underflow is set.
- Full with rd & wr in the same cycle: both occur, count stays at max, no overflow.
- overflow is set when wr & full & ~rd; the data is dropped and the FIFO is unchanged.
- underflow is set when rd & empty; pointers are unchanged.
- Both error flags are sticky and clear only on reset.
- All status outputs are combinational decodes of registered count. No glitch-sensitive use is expected.
- Reset mid-operation: reset wins over rd/wr in the same cycle, and all state returns to the reset values above.

Optional Feature:
Macro FIFO_FLUSH_EN.
- Defined: adds input port flush (1 bit). On a flush=1 cycle, w_ptr=r_ptr=0 and count=0; rd/wr in that cycle are ignored and overflow/underflow are not modified. Reset has priority over flush.
- Undefined: no flush port. Only reset clears the FIFO.

Decomposition:
- Package fifo_flex_pkg holds:
  - function fifo_depth(addr_w) returning 2**addr_w
  - a typedef for the status bundle (struct of empty, full, almost_empty, almost_full, overflow, underflow)
- One natural sub-module, fifo_flex_ctrl, owns pointers, count, error flags and flag decode, and outputs w_addr, r_addr and w_en.
- Storage is a register array in the top level, written on w_en.

Test Plan (ADDR_WIDTH=4, AFULL_THRESH=14, AEMPTY_THRESH=2):
- Reset, then write 0x01..0x10 over 16 cycles. Required: count steps 1..16; almost_empty drops when count=3; almost_full rises at count=14; full=1 at 16; r_data=0x01 throughout.
- At full, wr=1 with w_data=0xAA and rd=0. Required: overflow=1, count=16, and later reads return 0x01..0x10 with no 0xAA.
- At full, rd=1 and wr=1 with 0x55 simultaneously. Required: count=16, r_data=0x02 the next cycle, and 0x55 is read out last after wrap-around.
- Empty FIFO, rd=1 and wr=1 with 0x33. Required: underflow=1, count=1, r_data=0x33 the next cycle, empty=0.
- Write 20 words while reading continuously from the 3rd word onward, so the pointers wrap. Required: output order is identical to input order and count never exceeds 3.
- With FIFO_FLUSH_EN, load 5 words, then pulse flush with wr=1. Required: count=0, empty=1, the flags are unchanged, and the next written word is the next one read.
